puerto_periferico: RTL and testbench
====================================

PUERTO_PERIFERICO -- requirements
Module: puerto_periferico

Interface
REQ-001 Parameter: DEPTH, default 4, meaning number of entries in the output-write FIFO (power of two, minimum 2).
REQ-002 clk  input  1  single clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_en  input  1  CPU output-port write strobe, one cycle per write.
REQ-005 wr_sel  input  2  destination output port index (0..3).
REQ-006 wr_data  input  8  byte written by the CPU.
REQ-007 tx_valid  output  1  FIFO head entry available to the peripheral.
REQ-008 tx_port  output  2  port index of the head entry.
REQ-009 tx_data  output  8  byte of the head entry.
REQ-010 tx_ready  input  1  peripheral accepts the head entry.
REQ-011 rx_valid  input  1  peripheral offers a byte for a CPU input port.
REQ-012 rx_port  input  2  target input port index.
REQ-013 rx_data  input  8  offered byte.
REQ-014 rx_ready  output  1  block accepts the offered byte this cycle.
REQ-015 in1, in2, in3, in4  output  8 each  registered input-port values presented to the CPU input multiplexer.
REQ-016 rd_en  input  1  CPU input-port read strobe.
REQ-017 rd_sel  input  2  port index being read.
REQ-018 pend  output  4  per-port unread flag; bit k refers to in(k+1).
REQ-019 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-020 overflow  output  1  sticky flag: a CPU write was dropped.

Function
REQ-021 The FIFO shall store {port, data} entries in write order and operate first-word-fall-through.
REQ-022 tx_valid = (count != 0); tx_port/tx_data show the head entry whenever tx_valid is 1; both hold 0 when the FIFO is empty.
REQ-023 A pop occurs on any cycle with tx_valid && tx_ready; the next entry (if any) appears on the following cycle.
REQ-024 A push occurs on any cycle with wr_en && (count < DEPTH || pop); a pushed entry appears on tx_* no earlier than the next cycle.
REQ-025 Simultaneous push and pop shall leave count unchanged, including when full.
REQ-026 wr_en when full with no pop shall drop the write, leave the FIFO unchanged and set overflow, which remains 1 until reset.
REQ-027 Read and write pointers shall wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-028 fifo_full = (count == DEPTH), registered-state derived, with no combinational path from wr_en.
REQ-029 rx_ready = !pend[rx_port] || (rd_en && rd_sel == rx_port); this is the only combinational input-to-output path.
REQ-030 A transfer occurs when rx_valid && rx_ready; on the next edge, in(rx_port+1) <= rx_data and pend[rx_port] <= 1.
REQ-031 rd_en clears pend[rd_sel] on the next edge; if a transfer targets the same port in that cycle, set wins (pend stays 1, new data loaded).
REQ-032 rd_en on a port with pend = 0 shall have no effect; in1..in4 change only on a transfer.
REQ-033 Transfers and reads on different ports in the same cycle are independent.

Reset
REQ-034 On a clock edge with reset = 1: FIFO empty, pointers 0, tx_valid 0, tx_port 0, tx_data 0, fifo_full 0, overflow 0, pend 4'b0000, in1..in4 = 8'h00; rx_ready then evaluates to 1.
REQ-035 Reset asserted mid-operation shall discard all FIFO contents and pending data; wr_en, rx_valid and rd_en presented in the reset cycle are ignored.

Verification
REQ-036 Reset, then wr_en with (sel=2, 8'h5A), tx_ready=0 -> next cycle tx_valid=1, tx_port=2, tx_data=8'h5A; the entry is held until tx_ready=1, then tx_valid=0.
REQ-037 Five back-to-back writes 8'h01..8'h05 with tx_ready=0 (DEPTH=4) -> fifo_full=1 after the 4th write, overflow=1 after the 5th; draining yields 01,02,03,04 in order.
REQ-038 Full FIFO, wr_en (8'hAA) and tx_ready=1 in the same cycle -> overflow stays 0, count stays 4, 8'hAA emerges last.
REQ-039 rx_valid (port 1, 8'h3C) -> in2=8'h3C, pend=4'b0010; a second offer to port 1 sees rx_ready=0 until rd_en with rd_sel=1, which in that same cycle accepts it and pend[1] stays 1.
REQ-040 Pointer wrap: 10 interleaved push/pop pairs (8'h10..8'h19) -> output order preserved, count never exceeds 1.
REQ-041 Assert reset with 3 FIFO entries and pend=4'b1111 -> next cycle all outputs at REQ-034 values.

Source files
------------

// File: rtl/puerto_periferico.sv
// CPU I/O port block: output-write FIFO toward the peripheral
// and four single-entry registered input ports with unread flags.
module puerto_periferico #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       tx_valid,
  output logic [1:0] tx_port,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [1:0] rx_port,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [7:0] in3,
  output logic [7:0] in4,
  input  logic       rd_en,
  input  logic [1:0] rd_sel,
  output logic [3:0] pend,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          xfer;
  logic [7:0]    inreg [4];
  logic [9:0]    head;

  assign head      = mem[rptr];
  assign tx_valid  = (count != '0);
  assign fifo_full = (count == FULLC);
  assign pop       = tx_valid && tx_ready;
  assign push      = wr_en && (!fifo_full || pop);

  // Head is gated so an empty FIFO shows zeros, not stale data.
  assign tx_port = tx_valid ? head[9:8] : 2'b00;
  assign tx_data = tx_valid ? head[7:0] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {wr_sel, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign rx_ready = !pend[rx_port] ||
                    (rd_en && (rd_sel == rx_port));
  assign xfer     = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        inreg[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // A same-cycle transfer wins over the read clear.
        if (xfer && (rx_port == 2'(k))) begin
          inreg[k] <= rx_data;
          pend[k]  <= 1'b1;
        end else if (rd_en && (rd_sel == 2'(k))) begin
          pend[k]  <= 1'b0;
        end
      end
    end
  end

  assign in1 = inreg[0];
  assign in2 = inreg[1];
  assign in3 = inreg[2];
  assign in4 = inreg[3];

endmodule

// File: tb/tb_puerto_periferico.sv
// Bench for puerto_periferico: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_puerto_periferico;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic       tx_valid;
  logic [1:0] tx_port;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [1:0] rx_port;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] in1, in2, in3, in4;
  logic       rd_en;
  logic [1:0] rd_sel;
  logic [3:0] pend;
  logic       fifo_full;
  logic       overflow;

  puerto_periferico #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .tx_valid(tx_valid), .tx_port(tx_port),
    .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_port(rx_port),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .rd_en(rd_en), .rd_sel(rd_sel), .pend(pend),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  logic [9:0] q [$];
  logic [7:0] in_m [4];
  logic [3:0] pend_m;
  logic       ovf_m;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic       rdy;
    logic       popm;
    logic       pushm;
    logic [9:0] hd;
    logic [9:0] dummy;
    #1;
    rdy = !pend_m[rx_port] || (rd_en && rd_sel == rx_port);
    if (!reset) chk("rx_ready", 32'(rx_ready), 32'(rdy));
    if (reset) begin
      q.delete();
      pend_m = 4'b0000;
      ovf_m  = 1'b0;
      for (int k = 0; k < 4; k++) in_m[k] = 8'h00;
    end else begin
      popm  = (q.size() != 0) && tx_ready;
      pushm = wr_en && (q.size() < DEPTH || popm);
      if (popm) dummy = q.pop_front();
      if (pushm) q.push_back({wr_sel, wr_data});
      if (wr_en && !pushm) ovf_m = 1'b1;
      if (rd_en) pend_m[rd_sel] = 1'b0;
      if (rx_valid && rdy) begin
        in_m[rx_port]   = rx_data;
        pend_m[rx_port] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    hd = (q.size() != 0) ? q[0] : 10'h000;
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    chk("tx_port", 32'(tx_port), 32'(hd[9:8]));
    chk("tx_data", 32'(tx_data), 32'(hd[7:0]));
    chk("fifo_full", 32'(fifo_full),
        32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("pend", 32'(pend), 32'(pend_m));
    chk("in1", 32'(in1), 32'(in_m[0]));
    chk("in2", 32'(in2), 32'(in_m[1]));
    chk("in3", 32'(in3), 32'(in_m[2]));
    chk("in4", 32'(in4), 32'(in_m[3]));
  endtask

  task automatic idle();
    wr_en = 0; tx_ready = 0; rx_valid = 0; rd_en = 0;
  endtask

  logic [7:0] e;

  initial begin
    reset = 1; wr_sel = 0; wr_data = 0;
    rx_port = 0; rx_data = 0; rd_sel = 0;
    idle();
    pend_m = 0; ovf_m = 0;
    for (int k = 0; k < 4; k++) in_m[k] = 0;
    tick();
    tick();
    reset = 0;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);

    // single write held until accepted
    wr_en = 1; wr_sel = 2; wr_data = 8'h5A;
    tick();
    idle();
    chk("w1_valid", 32'(tx_valid), 32'd1);
    chk("w1_port", 32'(tx_port), 32'd2);
    chk("w1_data", 32'(tx_data), 32'h5A);
    tick();
    tick();
    chk("w1_hold", 32'(tx_data), 32'h5A);
    tx_ready = 1;
    tick();
    idle();
    chk("w1_gone", 32'(tx_valid), 32'd0);

    // fill past capacity, then drain
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1; wr_sel = 2'(i); wr_data = 8'(i);
      tick();
      if (i == 4) chk("full4", 32'(fifo_full), 32'd1);
      chk("ovf_seq", 32'(overflow), 32'(i == 5));
    end
    idle();
    tx_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain", 32'(tx_data), 32'(i));
      tick();
    end
    idle();
    chk("drained", 32'(tx_valid), 32'd0);

    // full FIFO with simultaneous push and pop
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_sel = 0; wr_data = 8'h20 + 8'(i);
      tick();
    end
    wr_en = 1; wr_data = 8'hAA; tx_ready = 1;
    tick();
    idle();
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_full", 32'(fifo_full), 32'd1);
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      e = (i < 3) ? 8'h21 + 8'(i) : 8'hAA;
      chk("pp_order", 32'(tx_data), 32'(e));
      tick();
    end
    idle();

    // input port handshake with read-and-refill
    rx_valid = 1; rx_port = 1; rx_data = 8'h3C;
    tick();
    idle();
    chk("rx_in2", 32'(in2), 32'h3C);
    chk("rx_pend", 32'(pend), 32'b0010);
    rx_valid = 1; rx_data = 8'hC3;
    #1;
    chk("rx_block", 32'(rx_ready), 32'd0);
    tick();
    chk("rx_keep", 32'(in2), 32'h3C);
    rd_en = 1; rd_sel = 1;
    #1;
    chk("rx_rdpass", 32'(rx_ready), 32'd1);
    tick();
    idle();
    chk("rx_new", 32'(in2), 32'hC3);
    chk("rx_pend2", 32'(pend), 32'b0010);

    // pointer wrap with interleaved push/pop
    for (int i = 0; i < 10; i++) begin
      wr_en = 1; wr_sel = 3; wr_data = 8'h10 + 8'(i);
      tick();
      idle();
      tx_ready = 1;
      chk("wrap", 32'(tx_data), 32'(8'h10 + 8'(i)));
      tick();
      idle();
    end

    // mid-operation reset
    for (int k = 0; k < 4; k++) begin
      wr_en = (k < 3); wr_data = 8'(k + 1);
      rx_valid = 1; rx_port = 2'(k);
      rx_data = 8'($urandom_range(1, 255));
      rd_en = 1; rd_sel = 2'(k);
      tick();
    end
    idle();
    chk("pre_pend", 32'(pend), 32'hF);
    reset = 1; wr_en = 1; rx_valid = 1; rd_en = 1;
    tick();
    reset = 0;
    idle();
    chk("mr_pend", 32'(pend), 32'd0);
    chk("mr_valid", 32'(tx_valid), 32'd0);
    chk("mr_in3", 32'(in3), 32'd0);
    chk("mr_rdy", 32'(rx_ready), 32'd1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 39) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_sel   = 2'($urandom_range(0, 3));
      wr_data  = 8'($urandom_range(0, 255));
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = 1'($urandom_range(0, 1));
      rx_port  = 2'($urandom_range(0, 3));
      rx_data  = 8'($urandom_range(0, 255));
      rd_en    = ($urandom_range(0, 2) == 0);
      rd_sel   = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 0;
    idle();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
